// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR addresses, mstatus layout, reset constants and decode helpers
package csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mstatus fields kept by this machine-mode-only hart
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;

  // What the state update does this cycle, already resolved by priority
  typedef enum logic [1:0] {
    CSR_ACT_NONE,
    CSR_ACT_WRITE,
    CSR_ACT_MRET,
    CSR_ACT_TRAP
  } csr_action_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic csr_read_only(input logic [11:0] addr);
    return addr == CSR_MHARTID;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// rtl/csr_regfile_if.sv - CSR read/write, trap/mret and redirect bundle
interface csr_regfile_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_rillegal;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_willegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            mret_valid;
  logic            inst_retire;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mstatus_mie;

  // Pipeline side drives requests, the register file answers
  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata,
    output trap_valid, trap_pc, trap_cause, trap_tval,
    output mret_valid, inst_retire,
    input  csr_rdata, csr_rillegal, csr_willegal,
    input  redirect_valid, redirect_pc, mstatus_mie
  );

  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  trap_valid, trap_pc, trap_cause, trap_tval,
    input  mret_valid, inst_retire,
    output csr_rdata, csr_rillegal, csr_willegal,
    output redirect_valid, redirect_pc, mstatus_mie
  );
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - free-running wrap-around counter with synchronous load
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // A software load replaces that cycle's increment; overflow wraps to zero
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file with trap entry, mret and cycle/instret counters
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input logic         clk,
  input logic         rstn,
  csr_regfile_if.slave bus
);

  // Direct-mode mtvec and 4-byte aligned mepc: low two bits are forced to zero
  localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            status_mie_q;
  logic            status_mpie_q;
  logic [XLEN-1:0] mie_csr_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;
  logic [XLEN-1:0] mstatus_value;
  logic            write_ok;
  csr_action_e     action;

  assign write_ok = bus.csr_we && csr_implemented(bus.csr_waddr)
                    && !csr_read_only(bus.csr_waddr);

  assign bus.csr_willegal   = bus.csr_we && !(csr_implemented(bus.csr_waddr)
                                              && !csr_read_only(bus.csr_waddr));
  assign bus.redirect_valid = bus.trap_valid || bus.mret_valid;
  assign bus.redirect_pc    = bus.trap_valid ? mtvec_q : mepc_q;
  assign bus.mstatus_mie    = status_mie_q;

  // Resolve trap > mret > software write; the losers are simply dropped
  always_comb begin
    action = CSR_ACT_NONE;
    if (bus.trap_valid) begin
      action = CSR_ACT_TRAP;
    end else if (bus.mret_valid) begin
      action = CSR_ACT_MRET;
    end else if (write_ok) begin
      action = CSR_ACT_WRITE;
    end
  end

  // mstatus is rebuilt from its two live bits; MPP is hardwired to machine mode
  always_comb begin
    mstatus_value = '0;
    mstatus_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_value[MSTATUS_MPIE_BIT] = status_mpie_q;
    mstatus_value[MSTATUS_MIE_BIT]  = status_mie_q;
  end

  // Old-value read port, no bypass of a write committing this cycle
  always_comb begin
    bus.csr_rdata    = '0;
    bus.csr_rillegal = 1'b0;
    case (bus.csr_raddr)
      CSR_MSTATUS:  bus.csr_rdata = mstatus_value;
      CSR_MIE:      bus.csr_rdata = mie_csr_q;
      CSR_MTVEC:    bus.csr_rdata = mtvec_q;
      CSR_MSCRATCH: bus.csr_rdata = mscratch_q;
      CSR_MEPC:     bus.csr_rdata = mepc_q;
      CSR_MCAUSE:   bus.csr_rdata = mcause_q;
      CSR_MTVAL:    bus.csr_rdata = mtval_q;
      CSR_MIP:      bus.csr_rdata = '0;
      CSR_MCYCLE:   bus.csr_rdata = mcycle;
      CSR_MINSTRET: bus.csr_rdata = minstret;
      CSR_MHARTID:  bus.csr_rdata = HART_ID;
      default:      bus.csr_rillegal = 1'b1;
    endcase
  end

  // Architectural state update for trap entry, mret and software writes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      status_mie_q  <= MSTATUS_RESET[MSTATUS_MIE_BIT];
      status_mpie_q <= MSTATUS_RESET[MSTATUS_MPIE_BIT];
      mie_csr_q     <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      case (action)
        CSR_ACT_TRAP: begin
          mepc_q        <= bus.trap_pc & ALIGN4_MASK;
          mcause_q      <= bus.trap_cause;
          mtval_q       <= bus.trap_tval;
          status_mpie_q <= status_mie_q;
          status_mie_q  <= 1'b0;
        end
        CSR_ACT_MRET: begin
          status_mie_q  <= status_mpie_q;
          status_mpie_q <= 1'b1;
        end
        CSR_ACT_WRITE: begin
          case (bus.csr_waddr)
            CSR_MSTATUS: begin
              status_mie_q  <= bus.csr_wdata[MSTATUS_MIE_BIT];
              status_mpie_q <= bus.csr_wdata[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_csr_q  <= bus.csr_wdata;
            CSR_MTVEC:    mtvec_q    <= bus.csr_wdata & ALIGN4_MASK;
            CSR_MSCRATCH: mscratch_q <= bus.csr_wdata;
            CSR_MEPC:     mepc_q     <= bus.csr_wdata & ALIGN4_MASK;
            CSR_MCAUSE:   mcause_q   <= bus.csr_wdata;
            CSR_MTVAL:    mtval_q    <= bus.csr_wdata;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  csr_counter64 #(.WIDTH(XLEN)) u_mcycle (
    .clk        (clk),
    .rstn       (rstn),
    .load       ((action == CSR_ACT_WRITE) && (bus.csr_waddr == CSR_MCYCLE)),
    .load_value (bus.csr_wdata),
    .inc        (1'b1),
    .count      (mcycle)
  );

  // An instruction that traps does not retire
  csr_counter64 #(.WIDTH(XLEN)) u_minstret (
    .clk        (clk),
    .rstn       (rstn),
    .load       ((action == CSR_ACT_WRITE) && (bus.csr_waddr == CSR_MINSTRET)),
    .load_value (bus.csr_wdata),
    .inc        (bus.inst_retire && !bus.trap_valid),
    .count      (minstret)
  );

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed and random checks of csr_regfile against a CSR table model
module tb_csr_regfile;

  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0100;
  localparam logic [63:0] HART      = 64'd3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   check_en = 1'b0;

  logic [63:0] mdl [int];
  logic [63:0] wmask [int];
  logic [11:0] addr_pool [14];

  csr_regfile_if #(.XLEN(64)) bus ();

  csr_regfile #(
    .XLEN        (64),
    .MTVEC_RESET (MTVEC_RST),
    .HART_ID     (HART)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [11:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : 64'h0;
  endfunction

  function automatic bit mdl_wr_legal(input logic [11:0] a);
    return mdl.exists(int'(a)) && (a != 12'hF14);
  endfunction

  task automatic mdl_reset();
    mdl.delete();
    mdl[12'h300] = 64'h1800; mdl[12'h304] = 0; mdl[12'h305] = MTVEC_RST;
    mdl[12'h340] = 0; mdl[12'h341] = 0; mdl[12'h342] = 0; mdl[12'h343] = 0;
    mdl[12'h344] = 0; mdl[12'hB00] = 0; mdl[12'hB02] = 0; mdl[12'hF14] = HART;
  endtask

  // Register table rules: trap, then mret, then a masked software write wins
  task automatic mdl_update();
    logic [63:0] ms;
    if (!rstn) begin
      mdl_reset();
      return;
    end
    ms = mdl[12'h300];
    mdl[12'hB00] = mdl[12'hB00] + 64'd1;
    if (bus.inst_retire && !bus.trap_valid) mdl[12'hB02] = mdl[12'hB02] + 64'd1;
    if (bus.trap_valid) begin
      mdl[12'h341] = bus.trap_pc & ~64'd3;
      mdl[12'h342] = bus.trap_cause;
      mdl[12'h343] = bus.trap_tval;
      mdl[12'h300] = 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
    end else if (bus.mret_valid) begin
      mdl[12'h300] = 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
    end else if (bus.csr_we && mdl_wr_legal(bus.csr_waddr)) begin
      mdl[int'(bus.csr_waddr)] = (mdl[int'(bus.csr_waddr)] & ~wmask[int'(bus.csr_waddr)])
                                 | (bus.csr_wdata & wmask[int'(bus.csr_waddr)]);
    end
  endtask

  task automatic idle();
    bus.csr_we = 1'b0; bus.csr_waddr = 12'h0; bus.csr_wdata = 64'h0;
    bus.trap_valid = 1'b0; bus.trap_pc = 64'h0; bus.trap_cause = 64'h0; bus.trap_tval = 64'h0;
    bus.mret_valid = 1'b0; bus.inst_retire = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.csr_we = 1'b1; bus.csr_waddr = a; bus.csr_wdata = d;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    bus.csr_raddr = a;
    #1;
    chk(tag, bus.csr_rdata, exp);
  endtask

  // Check combinational outputs against the model, then advance one clock
  task automatic run_cycle();
    bit tr;
    #1;
    if (check_en) begin
      tr = bus.trap_valid;
      chk("rdata", bus.csr_rdata, mdl_read(bus.csr_raddr));
      chk("rillegal", 64'(bus.csr_rillegal), 64'(mdl.exists(int'(bus.csr_raddr)) == 0));
      chk("willegal", 64'(bus.csr_willegal), 64'(bus.csr_we && !mdl_wr_legal(bus.csr_waddr)));
      chk("redirect_valid", 64'(bus.redirect_valid), 64'(bus.trap_valid || bus.mret_valid));
      if (bus.trap_valid || bus.mret_valid)
        chk("redirect_pc", bus.redirect_pc, tr ? mdl[12'h305] : mdl[12'h341]);
      chk("mstatus_mie", 64'(bus.mstatus_mie), 64'(mdl[12'h300][3]));
    end
    @(posedge clk);
    mdl_update();
    @(negedge clk);
  endtask

  initial begin
    wmask[12'h300] = 64'h88;        wmask[12'h304] = '1; wmask[12'h305] = ~64'd3;
    wmask[12'h340] = '1;            wmask[12'h341] = ~64'd3; wmask[12'h342] = '1;
    wmask[12'h343] = '1;            wmask[12'h344] = 64'h0; wmask[12'hB00] = '1;
    wmask[12'hB02] = '1;            wmask[12'hF14] = 64'h0;
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h301, 12'hF11};
    idle();
    bus.csr_raddr = 12'h300;
    rstn = 1'b0;
    run_cycle();
    check_en = 1'b1;
    rstn = 1'b1;

    // reset values and mcycle counting from zero
    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mtvec", 12'h305, MTVEC_RST);
    rd("rst_minstret", 12'hB02, 64'h0);
    rd("rst_mcycle0", 12'hB00, 64'h0);
    run_cycle(); rd("mcycle1", 12'hB00, 64'd1);
    run_cycle(); rd("mcycle2", 12'hB00, 64'd2);
    run_cycle(); rd("mcycle3", 12'hB00, 64'd3);

    // mtvec low bits forced to zero, no same-cycle bypass
    wr(12'h305, 64'h8000_0003);
    rd("mtvec_no_bypass", 12'h305, MTVEC_RST);
    run_cycle(); idle();
    rd("mtvec_masked", 12'h305, 64'h8000_0000);

    // trap entry with MIE set
    wr(12'h300, 64'h8); run_cycle(); idle();
    rd("mstatus_mie_set", 12'h300, 64'h1808);
    bus.trap_valid = 1'b1; bus.trap_pc = 64'h1004; bus.trap_cause = 64'd2; bus.trap_tval = 64'h77;
    #1; chk("trap_redirect_pc", bus.redirect_pc, 64'h8000_0000);
    run_cycle(); idle();
    rd("trap_mepc", 12'h341, 64'h1004);
    rd("trap_mcause", 12'h342, 64'd2);
    rd("trap_mstatus", 12'h300, 64'h1880);

    // mret back to the faulting pc
    bus.mret_valid = 1'b1;
    #1; chk("mret_redirect_pc", bus.redirect_pc, 64'h1004);
    run_cycle(); idle();
    rd("mret_mstatus", 12'h300, 64'h1888);

    // trap beats a simultaneous mscratch write
    bus.trap_valid = 1'b1; bus.trap_pc = 64'h2007; bus.trap_cause = 64'd5;
    wr(12'h340, 64'hAA);
    #1; chk("trap_we_redirect", 64'(bus.redirect_valid), 64'd1);
    run_cycle(); idle();
    rd("trap_we_mscratch", 12'h340, 64'h0);
    rd("trap_we_mepc", 12'h341, 64'h2004);

    // read-only and unimplemented addresses
    wr(12'hF14, 64'd5);
    #1; chk("mhartid_willegal", 64'(bus.csr_willegal), 64'd1);
    run_cycle(); idle();
    rd("mhartid_kept", 12'hF14, HART);
    rd("unimpl_rdata", 12'h7C0, 64'h0);
    chk("unimpl_rillegal", 64'(bus.csr_rillegal), 64'd1);
    wr(12'h344, 64'hFF);
    #1; chk("mip_willegal", 64'(bus.csr_willegal), 64'd0);
    run_cycle(); idle();
    rd("mip_zero", 12'h344, 64'h0);

    // counter wrap and load-over-increment
    wr(12'hB00, '1); run_cycle(); idle();
    rd("mcycle_max", 12'hB00, '1);
    run_cycle(); rd("mcycle_wrap", 12'hB00, 64'h0);
    wr(12'hB02, '1); bus.inst_retire = 1'b1; run_cycle();
    idle(); rd("minstret_load_wins", 12'hB02, '1);
    bus.inst_retire = 1'b1; run_cycle(); idle();
    rd("minstret_wrap", 12'hB02, 64'h0);

    // reset mid-operation discards concurrent trap and write
    wr(12'h340, 64'h55); bus.trap_valid = 1'b1; bus.trap_pc = 64'h40;
    rstn = 1'b0; run_cycle(); rstn = 1'b1; idle();
    rd("midrst_mstatus", 12'h300, 64'h1800);
    rd("midrst_mtvec", 12'h305, MTVEC_RST);
    rd("midrst_mepc", 12'h341, 64'h0);

    // random traffic against the table model
    for (int i = 0; i < 600; i++) begin
      idle();
      bus.csr_raddr  = addr_pool[$urandom_range(13)];
      bus.csr_we     = ($urandom_range(99) < 35);
      bus.csr_waddr  = addr_pool[$urandom_range(13)];
      bus.csr_wdata  = {$urandom, $urandom};
      bus.trap_valid = ($urandom_range(99) < 6);
      bus.trap_pc    = {$urandom, $urandom};
      bus.trap_cause = {$urandom, $urandom};
      bus.trap_tval  = {$urandom, $urandom};
      bus.mret_valid = ($urandom_range(99) < 8);
      bus.inst_retire = $urandom_range(1);
      rstn = ($urandom_range(199) != 0);
      run_cycle();
    end
    rstn = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
